// File: rtl/bitscan_pkg.sv
// Shared definitions for the bitscan encoder: FSM state encodings and default request width.
package bitscan_pkg;

    localparam int DIN_WIDTH_DEF = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/first_set_find.sv
// Combinational first-set-bit search. Scan order follows BITSCAN_ENCODER_MSB_FIRST_EN:
// defined -> highest set index wins, undefined -> lowest set index wins.
module first_set_find #(
    parameter int  DIN_WIDTH = bitscan_pkg::DIN_WIDTH_DEF,
    localparam int IDX_W     = $clog2(DIN_WIDTH)
) (
    input  logic [DIN_WIDTH-1:0] vec,
    output logic [IDX_W-1:0]     index,
    output logic                 any_set
);

    // The last matching assignment in the loop wins, so loop direction sets priority.
    always_comb begin
        index   = '0;
        any_set = |vec;
`ifdef BITSCAN_ENCODER_MSB_FIRST_EN
        for (int i = 0; i < DIN_WIDTH; i++) begin
            if (vec[i]) index = IDX_W'(i);
        end
`else
        for (int i = DIN_WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) index = IDX_W'(i);
        end
`endif
    end

endmodule

// File: rtl/bitscan_encoder.sv
// Captures a multi-hot request vector and emits one binary index per handshake beat.
// Scan order selected by BITSCAN_ENCODER_MSB_FIRST_EN (see first_set_find).
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | din_rdy=1, waiting for din_v to capture a vector
//   ST_SCAN | emitting indices of the pending vector, din ignored
module bitscan_encoder
    import bitscan_pkg::*;
#(
    parameter int  DIN_WIDTH = DIN_WIDTH_DEF,
    localparam int IDX_W     = $clog2(DIN_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIN_WIDTH-1:0] din,
    input  logic                 din_v,
    output logic                 din_rdy,
    output logic [IDX_W-1:0]     dout,
    output logic                 dout_v,
    input  logic                 dout_rdy,
    output logic                 dout_last,
    output logic                 dout_zero
);

    state_t               state;
    state_t               state_nxt;
    logic [DIN_WIDTH-1:0] pending;
    logic [DIN_WIDTH-1:0] pending_nxt;
    logic [IDX_W-1:0]     idx;
    logic                 any_set;
    logic                 one_left;
    logic                 scan;
    logic                 accept;

    first_set_find #(
        .DIN_WIDTH(DIN_WIDTH)
    ) u_find (
        .vec    (pending),
        .index  (idx),
        .any_set(any_set)
    );

    // pending can only be zero in SCAN when an all-zero vector was captured.
    assign scan      = (state == ST_SCAN);
    assign one_left  = any_set && ((pending & (pending - DIN_WIDTH'(1))) == '0);
    assign din_rdy   = !scan;
    assign dout_v    = scan;
    assign dout      = scan ? idx : '0;
    assign dout_last = scan && (one_left || !any_set);
    assign dout_zero = scan && !any_set;
    assign accept    = dout_v && dout_rdy;

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        case (state)
            ST_IDLE: begin
                if (din_v) begin
                    pending_nxt = din;
                    state_nxt   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (accept) begin
                    if (dout_last) begin
                        pending_nxt = '0;
                        state_nxt   = ST_IDLE;
                    end else begin
                        pending_nxt = pending & ~(DIN_WIDTH'(1) << idx);
                    end
                end
            end
            default: begin
                pending_nxt = '0;
                state_nxt   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            pending <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
        end
    end

endmodule

// File: tb/tb_bitscan_encoder.sv
// Directed scoreboard bench for bitscan_encoder; honours BITSCAN_ENCODER_MSB_FIRST_EN for scan order.
module tb_bitscan_encoder;

    localparam int W  = 8;
    localparam int IW = 3;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic          last;
        logic          zero;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  din = '0;
    logic          din_v = 1'b0;
    logic          din_rdy;
    logic [IW-1:0] dout;
    logic          dout_v;
    logic          dout_rdy = 1'b0;
    logic          dout_last;
    logic          dout_zero;

    beat_t q[$];
    int    n_checks = 0;
    int    n_fails  = 0;
    int    vcount   = 0;

    bitscan_encoder #(.DIN_WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .din_v    (din_v),
        .din_rdy  (din_rdy),
        .dout     (dout),
        .dout_v   (dout_v),
        .dout_rdy (dout_rdy),
        .dout_last(dout_last),
        .dout_zero(dout_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected beats for a captured vector, in scan order.
    task automatic push_vec(input logic [W-1:0] vec);
        beat_t b;
        int    k;
        int    n;
        k = $countones(vec);
        n = 0;
        if (k == 0) begin
            b.idx = '0; b.last = 1'b1; b.zero = 1'b1;
            q.push_back(b);
        end else begin
`ifdef BITSCAN_ENCODER_MSB_FIRST_EN
            for (int i = W - 1; i >= 0; i--) begin
`else
            for (int i = 0; i < W; i++) begin
`endif
                if (vec[i]) begin
                    n++;
                    b.idx = IW'(i); b.last = (n == k); b.zero = 1'b0;
                    q.push_back(b);
                end
            end
        end
    endtask

    // One clock: sample/compare on the falling edge, return just after the rising edge.
    task automatic tick();
        beat_t b;
        @(negedge clk);
        if (!rst && dout_v) begin
            vcount++;
            check("din_rdy_low_in_scan", {31'b0, din_rdy}, 32'd0);
            n_checks++;
            assert (q.size() > 0) else begin
                n_fails++;
                $error("FAIL unexpected_beat: observed dout=%0d last=%0b zero=%0b expected no beat",
                       dout, dout_last, dout_zero);
            end
            if (q.size() > 0) begin
                b = q[0];
                check("beat", {26'b0, dout, dout_last, dout_zero}, {26'b0, b.idx, b.last, b.zero});
                if (dout_rdy) void'(q.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] vec);
        for (int i = 0; i < 20 && !din_rdy; i++) tick();
        check("din_rdy_before_send", {31'b0, din_rdy}, 32'd1);
        din   = vec;
        din_v = 1'b1;
        push_vec(vec);
        tick();
        din_v = 1'b0;
        check("latency_dout_v", {31'b0, dout_v}, 32'd1);
    endtask

    task automatic wait_empty(input bit toggle);
        int n;
        n = 0;
        while (q.size() != 0 && n < 64) begin
            tick();
            if (toggle) dout_rdy = ~dout_rdy;
            n++;
        end
        check("drain_timeout", q.size(), 32'd0);
        check("din_rdy_after_last", {31'b0, din_rdy}, 32'd1);
        check("dout_v_after_last", {31'b0, dout_v}, 32'd0);
    endtask

    initial begin
        #1;
        check("rst_dout_v", {31'b0, dout_v}, 32'd0);
        check("rst_dout", {29'b0, dout}, 32'd0);
        check("rst_dout_last", {31'b0, dout_last}, 32'd0);
        check("rst_dout_zero", {31'b0, dout_zero}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("idle_din_rdy", {31'b0, din_rdy}, 32'd1);
        check("idle_dout_v", {31'b0, dout_v}, 32'd0);

        // single one-hot vector
        dout_rdy = 1'b1;
        send(8'b0000_0100);
        wait_empty(1'b0);

        // multi-hot, scan order
        send(8'b1001_0010);
        wait_empty(1'b0);

        // all-zero vector
        send(8'h00);
        wait_empty(1'b0);

        // back-pressure: ready toggles every cycle, first scan cycle ready
        dout_rdy = 1'b1;
        vcount   = 0;
        send(8'hFF);
        dout_rdy = 1'b1;
        wait_empty(1'b1);
        check("ff_valid_cycles", vcount, 32'd15);

        // din_v during SCAN must be ignored
        dout_rdy = 1'b0;
        send(8'b1001_0010);
        din   = 8'h01;
        din_v = 1'b1;
        tick();
        tick();
        din_v    = 1'b0;
        din      = '0;
        dout_rdy = 1'b1;
        wait_empty(1'b0);

        // reset mid-scan after two accepted beats
        dout_rdy = 1'b1;
        send(8'hF0);
        tick();
        tick();
        check("two_beats_accepted", q.size(), 32'd2);
        rst = 1'b1;
        #1;
        check("midrst_dout_v", {31'b0, dout_v}, 32'd0);
        check("midrst_dout", {29'b0, dout}, 32'd0);
        check("midrst_dout_last", {31'b0, dout_last}, 32'd0);
        q.delete();
        tick();
        rst = 1'b0;
        #1;
        check("postrst_din_rdy", {31'b0, din_rdy}, 32'd1);
        for (int i = 0; i < 5; i++) tick();
        check("postrst_no_beats", {31'b0, dout_v}, 32'd0);

        // recovery after reset
        send(8'h81);
        wait_empty(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
